four_bit_cpu: RTL and testbench
===============================

# four_bit_cpu

Minimal single-cycle 4-bit accumulator CPU and the top of the four-bit-computer design. It fetches 8-bit instructions from an internal 16-word program ROM addressed by a 4-bit program counter. It executes one instruction per clock and presents its accumulator on a registered 4-bit output port. The default program is a free-running counter, so the block is useful out of reset with no external memory.

## Interface
- `PROGRAM`, default `DEFAULT_PROGRAM` (128 bits): ROM image; word i = `PROGRAM[8*i+7 : 8*i]`.
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `output_data` output 4: registered value last written by `OUT`.
- Internal register named `pc` (4 bits) is the program counter; benches probe it hierarchically, so the name is fixed.

## Operation
- Instruction format: `[7:4]` opcode, `[3:0]` imm/addr. Internal state: `pc`, A (accumulator), B, flags Z and C, `halted`; all 4-bit except the 1-bit flags.
- Opcodes:
  - 0 `NOP`.
  - 1 `LDI`: A=imm; Z=(imm==0); C=0.
  - 2 `ADDI`: {C,A}=A+imm; Z=(A==0).
  - 3 `SUBI`: A=A-imm; C=borrow (A<imm); Z=(A==0).
  - 4 `MOVB`: B=A.
  - 5 `ADD`: {C,A}=A+B; Z=(A==0).
  - 6 `OUT`: output_data=A.
  - 7 `JMP`: pc=addr.
  - 8 `JC`: pc=addr if C, else pc+1.
  - 9 `JZ`: pc=addr if Z, else pc+1.
  - F `HLT`: set `halted`.
  - A–E: execute as `NOP`.
- Z and C are evaluated on the post-operation value. Instructions not listed as writing a flag leave it unchanged.
- Arithmetic is modulo 16. `pc` increments modulo 16, so 15 wraps to 0.
- Once `halted` is set, `pc`, registers, flags and `output_data` freeze until reset.
- `DEFAULT_PROGRAM`: 0:`LDI 0`, 1:`OUT`, 2:`ADDI 1`, 3:`JMP 1`, 4–15:`NOP`.

## Timing
- Reset asserted (`reset`=0), asynchronous: `pc`=0, A=0, B=0, Z=0, C=0, `halted`=0, `output_data`=0.
- Reset release takes effect at the next rising edge. The first edge after release executes ROM[0].
- Single-cycle execution: ROM read is combinational from `pc`. All state, including `output_data`, updates on the same rising edge as the instruction executes. Latency from `OUT` fetch to port change is one edge.
- Reset asserted mid-program aborts immediately: outputs return to reset values without waiting for a clock edge.
- A jump to its own address is a legal spin loop. `pc` stays constant but the CPU is not halted.

## Structure
- Package `cpu_pkg` holds:
  - opcode localparams (`OP_NOP`…`OP_HLT`);
  - `DEFAULT_PROGRAM`;
  - widths `DATA_W`=4, `ADDR_W`=4, `INSTR_W`=8.
- One sub-module `cpu_alu`, purely combinational. Inputs: op, A, operand. Outputs: result, carry, zero. Shared by `ADDI`, `SUBI` and `ADD`.
- ROM is a constant array built from `PROGRAM`. Decode and the register file live in the top.

## Test plan
- Reset: hold `reset`=0 for 2 edges → `pc`=0, `output_data`=0. Release → after edge 1 `pc`=1; after edge 2 `output_data`=0 and `pc`=2.
- Default counter: run 48 edges after release → `pc` cycles 1,2,3. `output_data` increments by 1 every 3 edges: 0,1,…,15, then wraps to 0.
- Async reset mid-run: drop `reset` between edges while `output_data`=5 → `output_data`=0 and `pc`=0 immediately, without a clock edge.
- Carry/branch: program `LDI 15; ADDI 1; JC 5; OUT; HLT; LDI 9; OUT; HLT` → `output_data`=9, then `pc` holds at 7.
- Zero/sub: program `LDI 3; SUBI 3; JZ 4; LDI 7; OUT; HLT` → `output_data`=0. Variant with `SUBI 4` → C=1, A=15, `output_data`=7.
- Halt/wrap: program of 15 `NOP`s followed by `HLT` at 15 → `pc` reaches 15 and freezes; edges continue with no state change. With all `NOP`s, `pc` wraps 15→0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encodings and the default ROM image for the four-bit CPU.
package cpu_pkg;

   localparam int unsigned DATA_W    = 4;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned INSTR_W   = 8;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned ROM_DEPTH = 16;
   localparam int unsigned ROM_W     = ROM_DEPTH * INSTR_W;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
   localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
   localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
   localparam logic [OP_W-1:0] OP_MOVB = 4'h4;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h5;
   localparam logic [OP_W-1:0] OP_OUT  = 4'h6;
   localparam logic [OP_W-1:0] OP_JMP  = 4'h7;
   localparam logic [OP_W-1:0] OP_JC   = 4'h8;
   localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
   localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

   // Free-running counter: LDI 0; OUT; ADDI 1; JMP 1; NOPs.
   localparam logic [ROM_W-1:0] DEFAULT_PROGRAM = 128'h0000_0000_0000_0000_0000_0000_7121_6010;

endpackage

// File: rtl/cpu_alu.sv
// Combinational adder/subtractor shared by ADDI, SUBI and ADD.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_operand,
   output logic [DATA_W-1:0] o_result_c,
   output logic              o_carry_c,
   output logic              o_zero_c
);

   logic [DATA_W:0] w_wide;

   // The extra top bit is carry on add and borrow on subtract.
   always_comb begin
      w_wide = '0;
      if (i_op == OP_SUBI) begin
         w_wide = {1'b0, i_a} - {1'b0, i_operand};
      end else begin
         w_wide = {1'b0, i_a} + {1'b0, i_operand};
      end
      o_result_c = w_wide[DATA_W-1:0];
      o_carry_c  = w_wide[DATA_W];
      o_zero_c   = (w_wide[DATA_W-1:0] == '0);
   end

endmodule

// File: rtl/four_bit_cpu.sv
// Single-cycle 4-bit accumulator CPU with an internal 16-word program ROM.
module four_bit_cpu
   import cpu_pkg::*;
#(
   parameter logic [ROM_W-1:0] PROGRAM = DEFAULT_PROGRAM
)
(
   input  logic              clk,
   input  logic              reset,
   output logic [DATA_W-1:0] output_data
);

   logic [ADDR_W-1:0]  pc;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic               r_z;
   logic               r_c;
   logic               r_halted;
   logic [DATA_W-1:0]  r_out;

   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [DATA_W-1:0]  w_a_nxt;
   logic [DATA_W-1:0]  w_b_nxt;
   logic               w_z_nxt;
   logic               w_c_nxt;
   logic               w_halted_nxt;
   logic [DATA_W-1:0]  w_out_nxt;

   logic [INSTR_W-1:0] w_rom [ROM_DEPTH];
   logic [INSTR_W-1:0] w_instr;
   logic [OP_W-1:0]    w_op;
   logic [DATA_W-1:0]  w_imm;
   logic [DATA_W-1:0]  w_alu_operand;
   logic [DATA_W-1:0]  w_alu_result;
   logic               w_alu_carry;
   logic               w_alu_zero;

   for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign w_rom[gi] = PROGRAM[INSTR_W*gi +: INSTR_W];
   end

   assign w_instr       = w_rom[pc];
   assign w_op          = w_instr[INSTR_W-1:DATA_W];
   assign w_imm         = w_instr[DATA_W-1:0];
   assign w_alu_operand = (w_op == OP_ADD) ? r_b : w_imm;
   assign output_data   = r_out;

   cpu_alu u_alu (
      .i_op       (w_op),
      .i_a        (r_a),
      .i_operand  (w_alu_operand),
      .o_result_c (w_alu_result),
      .o_carry_c  (w_alu_carry),
      .o_zero_c   (w_alu_zero)
   );

   // Decode/execute: everything holds by default; a halted core keeps pc too.
   always_comb begin
      w_pc_nxt     = pc + ADDR_W'(1);
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_z_nxt      = r_z;
      w_c_nxt      = r_c;
      w_halted_nxt = r_halted;
      w_out_nxt    = r_out;
      if (r_halted) begin
         w_pc_nxt = pc;
      end else begin
         case (w_op)
            OP_LDI: begin
               w_a_nxt = w_imm;
               w_z_nxt = (w_imm == '0);
               w_c_nxt = 1'b0;
            end
            OP_ADDI, OP_SUBI, OP_ADD: begin
               w_a_nxt = w_alu_result;
               w_z_nxt = w_alu_zero;
               w_c_nxt = w_alu_carry;
            end
            OP_MOVB: w_b_nxt   = r_a;
            OP_OUT:  w_out_nxt = r_a;
            OP_JMP:  w_pc_nxt  = w_imm;
            OP_JC:   if (r_c) w_pc_nxt = w_imm;
            OP_JZ:   if (r_z) w_pc_nxt = w_imm;
            OP_HLT: begin
               w_halted_nxt = 1'b1;
               w_pc_nxt     = pc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_halted <= 1'b0;
         r_out    <= '0;
      end else begin
         pc       <= w_pc_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_z      <= w_z_nxt;
         r_c      <= w_c_nxt;
         r_halted <= w_halted_nxt;
         r_out    <= w_out_nxt;
      end
   end

endmodule

// File: tb/tb_four_bit_cpu.sv
// Directed bench: default counter via a vector table, then small programs for flags, branches and halt.
module tb_four_bit_cpu;

   logic clk;
   logic rst_a;
   logic rst_b;
   logic [3:0] out_def, out_carry, out_sub0, out_sub4, out_halt, out_nop;

   int n_pass  = 0;
   int n_total = 0;
   int n_edge  = 0;

   typedef struct {
      int n;
      int pc;
      int out;
   } vec_t;

   vec_t tbl [12];

   four_bit_cpu u_def (.clk(clk), .reset(rst_a), .output_data(out_def));

   // LDI 15; ADDI 1; JC 5; OUT; HLT; LDI 9; OUT; HLT
   four_bit_cpu #(.PROGRAM(128'h0000_0000_0000_0000_F060_19F0_6085_211F))
      u_carry (.clk(clk), .reset(rst_b), .output_data(out_carry));
   // LDI 3; SUBI 3; JZ 4; LDI 7; OUT; HLT
   four_bit_cpu #(.PROGRAM(128'h0000_0000_0000_0000_0000_F060_1794_3313))
      u_sub0 (.clk(clk), .reset(rst_b), .output_data(out_sub0));
   // LDI 3; SUBI 4; JZ 4; LDI 7; OUT; HLT
   four_bit_cpu #(.PROGRAM(128'h0000_0000_0000_0000_0000_F060_1794_3413))
      u_sub4 (.clk(clk), .reset(rst_b), .output_data(out_sub4));
   // 15 NOPs then HLT at 15
   four_bit_cpu #(.PROGRAM(128'hF000_0000_0000_0000_0000_0000_0000_0000))
      u_halt (.clk(clk), .reset(rst_b), .output_data(out_halt));
   // all NOPs
   four_bit_cpu #(.PROGRAM(128'h0))
      u_nop (.clk(clk), .reset(rst_b), .output_data(out_nop));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   initial begin
      // Default counter checkpoints: {edges after release, pc, output_data}
      tbl[0]  = '{1,  1, 0};
      tbl[1]  = '{2,  2, 0};
      tbl[2]  = '{3,  3, 0};
      tbl[3]  = '{4,  1, 0};
      tbl[4]  = '{5,  2, 1};
      tbl[5]  = '{8,  2, 2};
      tbl[6]  = '{11, 2, 3};
      tbl[7]  = '{29, 2, 9};
      tbl[8]  = '{47, 2, 15};
      tbl[9]  = '{48, 3, 15};
      tbl[10] = '{49, 1, 15};
      tbl[11] = '{50, 2, 0};

      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      tick();
      check("reset_pc",   int'(u_def.pc), 0);
      check("reset_out",  int'(out_def), 0);
      check("reset_a",    int'(u_def.r_a), 0);
      check("reset_halt", int'(u_def.r_halted), 0);

      rst_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         while (n_edge < tbl[i].n) begin
            tick();
            n_edge++;
         end
         check($sformatf("ctr_pc@%0d", tbl[i].n),  int'(u_def.pc), tbl[i].pc);
         check($sformatf("ctr_out@%0d", tbl[i].n), int'(out_def), tbl[i].out);
      end

      // Asynchronous reset between edges while output_data is 5
      while (n_edge < 65) begin
         tick();
         n_edge++;
      end
      check("pre_areset_out", int'(out_def), 5);
      check("pre_areset_pc",  int'(u_def.pc), 2);
      #2 rst_a = 1'b0;
      #1;
      check("areset_out", int'(out_def), 0);
      check("areset_pc",  int'(u_def.pc), 0);
      check("areset_a",   int'(u_def.r_a), 0);

      // Small programs, released together
      rst_b  = 1'b1;
      n_edge = 0;
      tick(); tick(); n_edge = 2;
      check("carry_c_after_addi", int'(u_carry.r_c), 1);
      check("carry_a_after_addi", int'(u_carry.r_a), 0);
      check("sub0_z_after_subi",  int'(u_sub0.r_z), 1);
      check("sub4_a_after_subi",  int'(u_sub4.r_a), 15);
      check("sub4_c_after_subi",  int'(u_sub4.r_c), 1);
      check("sub4_z_after_subi",  int'(u_sub4.r_z), 0);

      while (n_edge < 6) begin
         tick();
         n_edge++;
      end
      check("carry_out",    int'(out_carry), 9);
      check("carry_pc",     int'(u_carry.pc), 7);
      check("carry_halted", int'(u_carry.r_halted), 1);
      check("sub0_out",     int'(out_sub0), 0);
      check("sub0_pc",      int'(u_sub0.pc), 5);
      check("sub4_out",     int'(out_sub4), 7);

      while (n_edge < 14) begin
         tick();
         n_edge++;
      end
      check("carry_pc_hold", int'(u_carry.pc), 7);
      check("sub4_pc_hold",  int'(u_sub4.pc), 5);
      check("halt_pc@14",    int'(u_halt.pc), 14);
      check("halt_not_yet",  int'(u_halt.r_halted), 0);

      tick(); n_edge++;
      check("halt_pc@15", int'(u_halt.pc), 15);
      check("nop_pc@15",  int'(u_nop.pc), 15);

      tick(); n_edge++;
      check("halt_pc@16", int'(u_halt.pc), 15);
      check("halt_flag",  int'(u_halt.r_halted), 1);
      check("nop_wrap",   int'(u_nop.pc), 0);

      while (n_edge < 24) begin
         tick();
         n_edge++;
      end
      check("halt_pc@24",  int'(u_halt.pc), 15);
      check("halt_out@24", int'(out_halt), 0);
      check("nop_pc@24",   int'(u_nop.pc), 8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
